// File: rtl/div_seq_if.sv
// Handshake and result bundle between the EX-stage decode path and the
// shared DIV/DIVU sequencer.
//   start      : DIV/DIVU present in EX
//   signed_div : 1 = DIV, 0 = DIVU
//   annul      : flush/exception kill of the EX instruction
//   a, b       : dividend (rs), divisor (rt)
//   stall      : hold IF..EX while the divide is in flight
//   ready      : one-cycle pulse, hi/lo valid this cycle
//   hilo_we    : HI/LO write strobe, decoder encoding (01 = write both)
//   hi, lo     : remainder, quotient (registered)
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_div;
  logic             annul;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             stall;
  logic             ready;
  logic [1:0]       hilo_we;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, signed_div, annul, a, b,
    input  stall, ready, hilo_we, hi, lo
  );

  modport slave (
    input  start, signed_div, annul, a, b,
    output stall, ready, hilo_we, hi, lo
  );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider sequencer for DIV/DIVU in EX.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : div_seq_if slave (start/signed_div/annul/a/b in,
//          stall/ready/hilo_we/hi/lo out)
// A normal divide takes WIDTH BUSY cycles followed by one DONE cycle in
// which the quotient (LO) and remainder (HI) are presented with the write
// strobe. Divide by zero short-circuits through ZERO.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ZERO, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             sgn_quo_q, sgn_quo_d;
  logic             sgn_rem_q, sgn_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]   rem_sh;
  logic             fits;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;

  // Two's-complement negate with WIDTH-bit wrap.
  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  // Magnitude when the operand is treated as signed, raw value otherwise.
  // The most negative value maps to itself, which is what makes the
  // 0x80000000 / -1 overflow case come out right without special handling.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x,
                                           input logic               is_signed);
    return (is_signed && x[WIDTH-1]) ? neg(x) : x;
  endfunction

  // One restoring step: shift {rem, quo} left, trial-subtract the divisor.
  // The shifted remainder needs one extra bit so large unsigned divisors
  // compare correctly; after a successful subtract the result fits in WIDTH.
  always_comb begin
    rem_sh   = {rem_q, quo_q[WIDTH-1]};
    fits     = (rem_sh >= {1'b0, div_q});
    rem_step = fits ? (rem_sh[WIDTH-1:0] - div_q) : rem_sh[WIDTH-1:0];
    quo_step = {quo_q[WIDTH-2:0], fits};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    sgn_quo_d = sgn_quo_q;
    sgn_rem_d = sgn_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (bus.annul) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.b != '0) begin
              rem_d     = '0;
              quo_d     = mag(bus.a, bus.signed_div);
              div_d     = mag(bus.b, bus.signed_div);
              sgn_quo_d = bus.signed_div & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              sgn_rem_d = bus.signed_div & bus.a[WIDTH-1];
              cnt_d     = '0;
              state_d   = BUSY;
            end else begin
              // Divide by zero: park the fixed result in the working regs.
              rem_d     = bus.a;
              quo_d     = '1;
              sgn_quo_d = 1'b0;
              sgn_rem_d = 1'b0;
              state_d   = ZERO;
            end
          end
        end
        BUSY: begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            hi_d    = sgn_rem_q ? neg(rem_step) : rem_step;
            lo_d    = sgn_quo_q ? neg(quo_step) : quo_step;
            state_d = DONE;
          end
        end
        ZERO: begin
          hi_d    = rem_q;
          lo_d    = quo_q;
          state_d = DONE;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      sgn_quo_q <= 1'b0;
      sgn_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      sgn_quo_q <= sgn_quo_d;
      sgn_rem_q <= sgn_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // An annul in DONE suppresses the write so a killed DIV never commits.
  assign bus.stall   = !bus.annul &&
                       ((state_q == IDLE && bus.start) ||
                        state_q == BUSY || state_q == ZERO);
  assign bus.ready   = (state_q == DONE) && !bus.annul;
  assign bus.hilo_we = bus.ready ? 2'b01 : 2'b00;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_seq_if #(.WIDTH(W)) dif();

  div_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sgn;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: MIPS DIV/DIVU semantics from plain arithmetic. Signed uses
  // 64-bit math (truncating division, remainder takes dividend sign) so
  // the -2^31 / -1 case wraps back to 0x80000000 on truncation.
  task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sgn, output logic [W-1:0] lo,
                         output logic [W-1:0] hi);
    longint sa, sb, q, r;
    if (b == 0) begin
      lo = '1;
      hi = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      lo = q[W-1:0];
      hi = r[W-1:0];
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endtask

  // Launch one divide at the next negedge and follow it to the ready pulse.
  task automatic run_div(input string nm, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic sgn,
                         input logic [W-1:0] elo, input logic [W-1:0] ehi,
                         output int rdy_cyc);
    int lat;
    int bad;
    bit seen;
    lat  = 0;
    bad  = 0;
    seen = 0;
    @(negedge clk);
    dif.start      = 1'b1;
    dif.a          = a;
    dif.b          = b;
    dif.signed_div = sgn;
    #1;
    if (dif.stall !== 1'b1) bad++;
    while (!seen && lat < 100) begin
      @(negedge clk);
      dif.start      = 1'b0;
      dif.a          = $urandom;
      dif.b          = $urandom;
      dif.signed_div = 1'($urandom);
      lat++;
      #1;
      if (dif.ready === 1'b1) seen = 1;
      else if (dif.stall !== 1'b1 || dif.hilo_we !== 2'b00) bad++;
    end
    chk({nm, "_latency"}, lat, (b == 0) ? 2 : 33);
    chk({nm, "_stall_profile"}, bad, 0);
    chk({nm, "_lo"}, dif.lo, elo);
    chk({nm, "_hi"}, dif.hi, ehi);
    chk({nm, "_hilo_we"}, dif.hilo_we, 2'b01);
    chk({nm, "_stall_done"}, dif.stall, 1'b0);
    rdy_cyc = cyc;
  endtask

  initial begin
    int t1, t2, bad;
    logic [W-1:0] ra, rb, elo, ehi;
    logic rs;

    vecs[0] = '{"divu_100_7",   32'd100,        32'd7,          1'b0, 32'd14,       32'd2};
    vecs[1] = '{"div_m7_2",     32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[2] = '{"div_7_m2",     32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD, 32'd1};
    vecs[3] = '{"div_ovf",      32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000, 32'd0};
    vecs[4] = '{"div_by_zero",  32'h00001234,   32'd0,          1'b1, 32'hFFFFFFFF, 32'h00001234};

    rst            = 1'b1;
    dif.start      = 1'b0;
    dif.signed_div = 1'b0;
    dif.annul      = 1'b0;
    dif.a          = '0;
    dif.b          = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_stall", dif.stall, 1'b0);
    chk("reset_ready", dif.ready, 1'b0);
    chk("reset_hilo_we", dif.hilo_we, 2'b00);
    chk("reset_hi", dif.hi, '0);
    chk("reset_lo", dif.lo, '0);

    // Directed vectors.
    for (int i = 0; i < 5; i++)
      run_div(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sgn,
              vecs[i].lo, vecs[i].hi, t1);

    // Randomized vectors against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = '0;
        1: rb = W'($urandom_range(1, 20));
        2: rb = -W'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      rs = 1'($urandom);
      ref_div(ra, rb, rs, elo, ehi);
      run_div($sformatf("rand%0d", i), ra, rb, rs, elo, ehi, t1);
    end

    // Annul during BUSY: no write, results preserved, next divide normal.
    run_div("pre_annul", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, t1);
    @(negedge clk);
    dif.start = 1'b1; dif.a = 32'd1000; dif.b = 32'd3; dif.signed_div = 1'b0;
    repeat (10) begin
      @(negedge clk);
      dif.start = 1'b0;
    end
    dif.annul = 1'b1;
    #1;
    chk("annul_stall_same_cycle", dif.stall, 1'b0);
    chk("annul_ready_same_cycle", dif.ready, 1'b0);
    @(negedge clk);
    dif.annul = 1'b0;
    #1;
    chk("annul_stall_after", dif.stall, 1'b0);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (dif.ready !== 1'b0 || dif.hilo_we !== 2'b00 || dif.stall !== 1'b0) bad++;
    end
    chk("annul_no_write", bad, 0);
    chk("annul_hi_kept", dif.hi, 32'd2);
    chk("annul_lo_kept", dif.lo, 32'd14);
    run_div("post_annul", 32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, t1);

    // Reset during BUSY.
    @(negedge clk);
    dif.start = 1'b1; dif.a = 32'd50; dif.b = 32'd5; dif.signed_div = 1'b0;
    repeat (5) begin
      @(negedge clk);
      dif.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_stall", dif.stall, 1'b0);
    chk("rst_mid_ready", dif.ready, 1'b0);
    chk("rst_mid_hi", dif.hi, '0);
    chk("rst_mid_lo", dif.lo, '0);
    bad = 0;
    repeat (35) begin
      @(negedge clk);
      #1;
      if (dif.ready !== 1'b0 || dif.stall !== 1'b0) bad++;
    end
    chk("rst_mid_stays_idle", bad, 0);

    // Back-to-back DIVUs, second start in the cycle after DONE.
    run_div("b2b_first", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, t1);
    run_div("b2b_second", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, t2);
    chk("b2b_gap", t2 - t1, 34);
    @(negedge clk);
    #1;
    chk("b2b_single_pulse", dif.ready, 1'b0);
    chk("b2b_hold_lo", dif.lo, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
